// File: rtl/pipe_add_pkg.sv
// Shared constants for the pipelined adder/subtractor: mode encoding and
// default geometry.
package pipe_add_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 2;

endpackage

// File: rtl/add_slice.sv
// Combinational SW-bit ripple of full adders; also exposes the carry into the
// slice MSB so the last slice can derive signed overflow.
module add_slice
  import pipe_add_pkg::*;
#(
  parameter int SW = 4
) (
  input  logic [SW-1:0] x,
  input  logic [SW-1:0] y,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co,
  output logic          c_msb_in
);

  // The chain is walked with a block-local carry so the ripple is a single
  // combinational process rather than a self-referencing vector.
  always_comb begin
    logic w_c;
    s        = '0;
    c_msb_in = ci;
    w_c      = ci;
    for (int i = 0; i < SW; i++) begin
      if (i == SW - 1) begin
        c_msb_in = w_c;
      end
      s[i] = x[i] ^ y[i] ^ w_c;
      w_c  = (x[i] & y[i]) | (w_c & (x[i] ^ y[i]));
    end
    co = w_c;
  end

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined ripple-carry adder/subtractor: one SLICE-bit carry slice per stage,
// global stall on backpressure, valid/ready on both sides.
module pipe_add_sub
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;

  logic                         w_advance;
  logic                         w_is_sub;
  logic                         w_ovf;
  logic [STAGES-1:0]            w_valid;
  logic [STAGES-1:0]            w_sub;
  logic [STAGES-1:0]            w_carry;
  logic [STAGES-1:0][WIDTH-1:0] w_word;

  assign w_advance = out_ready || !out_valid;
  assign in_ready  = w_advance;
  assign w_is_sub  = (sub == MODE_SUB);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO     = gi * SLICE;
    localparam int B_IN_W = WIDTH - LO;

    logic              w_valid_in;
    logic              w_sub_in;
    logic              w_c_in;
    logic [WIDTH-1:0]  w_word_in;
    logic [WIDTH-1:0]  w_word_next;
    logic [B_IN_W-1:0] w_b_in;
    logic [SLICE-1:0]  w_s;
    logic              w_co;
    logic              w_c_msb;

    logic              r_valid;
    logic              r_sub;
    logic              r_carry;
    logic [WIDTH-1:0]  r_word;

    // The word starts as operand A; each stage overwrites its slice with sum
    // bits, so unprocessed A slices and finished sum slices share one register.
    if (gi == 0) begin : g_src
      assign w_valid_in = in_valid;
      assign w_sub_in   = w_is_sub;
      assign w_c_in     = cin ^ w_is_sub;
      assign w_word_in  = a;
      assign w_b_in     = b ^ {WIDTH{w_is_sub}};
    end else begin : g_src
      assign w_valid_in = w_valid[gi-1];
      assign w_sub_in   = w_sub[gi-1];
      assign w_c_in     = w_carry[gi-1];
      assign w_word_in  = w_word[gi-1];
      assign w_b_in     = g_stage[gi-1].g_fwd.r_b;
    end

    add_slice #(.SW(SLICE)) u_slice (
      .x        (w_word_in[LO +: SLICE]),
      .y        (w_b_in[SLICE-1:0]),
      .ci       (w_c_in),
      .s        (w_s),
      .co       (w_co),
      .c_msb_in (w_c_msb)
    );

    always_comb begin
      w_word_next              = w_word_in;
      w_word_next[LO +: SLICE] = w_s;
    end

    // Data only loads with a valid transaction so outputs hold across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_sub   <= 1'b0;
        r_carry <= 1'b0;
        r_word  <= '0;
      end else if (w_advance) begin
        r_valid <= w_valid_in;
        if (w_valid_in) begin
          r_sub   <= w_sub_in;
          r_carry <= w_co;
          r_word  <= w_word_next;
        end
      end
    end

    assign w_valid[gi] = r_valid;
    assign w_sub[gi]   = r_sub;
    assign w_carry[gi] = r_carry;
    assign w_word[gi]  = r_word;

    if (gi < STAGES - 1) begin : g_fwd
      logic [B_IN_W-SLICE-1:0] r_b;
      logic                    w_unused_c_msb;

      assign w_unused_c_msb = w_c_msb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_b <= '0;
        end else if (w_advance && w_valid_in) begin
          r_b <= w_b_in[B_IN_W-1:SLICE];
        end
      end
    end else begin : g_ovf
      logic r_ovf;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_advance && w_valid_in) begin
          r_ovf <= w_c_msb ^ w_co;
        end
      end

      assign w_ovf = r_ovf;
    end
  end

  assign out_valid = w_valid[STAGES-1];
  assign sum       = w_word[STAGES-1];
  // Subtraction reports borrow, the complement of the raw carry.
  assign cout      = w_carry[STAGES-1] ^ w_sub[STAGES-1];
  assign ovf       = w_ovf;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: several geometries share one stimulus stream; each
// has its own scoreboard fed from an arithmetic reference model.
module tb_pipe_add_sub;

  localparam int NCFG = 5;
  localparam int CFG_W [NCFG] = '{8, 8, 8, 8, 16};
  localparam int CFG_S [NCFG] = '{2, 1, 4, 8, 4};

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;

  logic [NCFG-1:0] in_ready_v;
  logic [NCFG-1:0] out_valid_v;
  logic [NCFG-1:0] cout_v;
  logic [NCFG-1:0] ovf_v;
  logic [NCFG-1:0] drained_v;
  logic [15:0]     sum_v [NCFG];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Signed and unsigned integer arithmetic straight from the definitions.
  function automatic exp_t ref_model(input int w, input logic [15:0] av,
                                     input logic [15:0] bv, input logic ci,
                                     input logic is_sub);
    longint m, half, ua, ub, sa, sb, c, r, sr;
    exp_t   e;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(av) & m;
    ub   = longint'(bv) & m;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    c    = ci ? 1 : 0;
    if (!is_sub) begin
      r      = ua + ub + c;
      sr     = sa + sb + c;
      e.cout = (r > m);
    end else begin
      r      = ua - ub - c;
      sr     = sa - sb - c;
      e.cout = (r < 0);
    end
    e.sum = 16'(r & m);
    e.ovf = (sr < -half) || (sr >= half);
    return e;
  endfunction

  function automatic logic [15:0] rand_operand();
    logic [15:0] corners [7] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF,
                                 16'h0080, 16'h007F, 16'h00FF};
    if ($urandom_range(3) == 0) return corners[$urandom_range(6)];
    return 16'($urandom);
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int W = CFG_W[gi];
    localparam int S = CFG_S[gi];

    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_cout;
    logic         w_ovf;
    logic [W-1:0] w_sum;
    exp_t         q [$];
    logic         held;
    logic [W+1:0] held_val;
    int           n_pend;

    pipe_add_sub #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (w_in_ready),
      .a         (a[W-1:0]),
      .b         (b[W-1:0]),
      .cin       (cin),
      .sub       (sub),
      .out_valid (w_out_valid),
      .out_ready (out_ready),
      .sum       (w_sum),
      .cout      (w_cout),
      .ovf       (w_ovf)
    );

    assign in_ready_v[gi]  = w_in_ready;
    assign out_valid_v[gi] = w_out_valid;
    assign cout_v[gi]      = w_cout;
    assign ovf_v[gi]       = w_ovf;
    assign sum_v[gi]       = 16'(w_sum);
    assign drained_v[gi]   = (n_pend == 0);

    // Monitor: handshakes seen here complete on the following rising edge.
    always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        held     <= 1'b0;
        held_val <= '0;
        n_pend   <= 0;
      end else begin
        if (held) begin
          check($sformatf("cfg%0d stall out_valid", gi), w_out_valid, 1);
          check($sformatf("cfg%0d stall hold", gi), {w_cout, w_ovf, w_sum}, held_val);
        end
        if (w_out_valid && out_ready) begin
          if (q.size() == 0) begin
            check($sformatf("cfg%0d spurious result", gi), w_out_valid, 0);
          end else begin
            check($sformatf("cfg%0d sum", gi), w_sum, q[0].sum);
            check($sformatf("cfg%0d cout", gi), w_cout, q[0].cout);
            check($sformatf("cfg%0d ovf", gi), w_ovf, q[0].ovf);
            $display("cfg%0d W=%0d S=%0d result sum=%h cout=%0d ovf=%0d (model sum=%h cout=%0d ovf=%0d)",
                     gi, W, S, w_sum, w_cout, w_ovf, q[0].sum[W-1:0], q[0].cout, q[0].ovf);
            q.delete(0);
          end
        end
        held     <= w_out_valid && !out_ready;
        held_val <= {w_cout, w_ovf, w_sum};
        if (in_valid && w_in_ready) begin
          q.push_back(ref_model(W, a, b, cin, sub));
        end
        n_pend <= q.size();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv,
                       input logic c, input logic s);
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = c;
    sub      = s;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, rand_operand(), rand_operand(), 1'($urandom), 1'($urandom));
  endtask

  // Single transaction on the WIDTH=8, STAGES=2 instance with exact latency.
  task automatic directed(input string nm, input logic [15:0] av, input logic [15:0] bv,
                          input logic c, input logic s, input logic [7:0] es,
                          input logic ec, input logic eo);
    out_ready = 1'b1;
    drive(1'b1, av, bv, c, s);
    check({nm, " in_ready"}, in_ready_v[0], 1);
    tick();
    in_valid = 1'b0;
    check({nm, " out_valid after 1 cycle"}, out_valid_v[0], 0);
    tick();
    check({nm, " out_valid after 2 cycles"}, out_valid_v[0], 1);
    check({nm, " sum"}, sum_v[0], es);
    check({nm, " cout"}, cout_v[0], ec);
    check({nm, " ovf"}, ovf_v[0], eo);
    repeat (10) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) tick();
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("cfg%0d reset out_valid", i), out_valid_v[i], 0);
      check($sformatf("cfg%0d reset sum", i), sum_v[i], 0);
      check($sformatf("cfg%0d reset cout", i), cout_v[i], 0);
      check($sformatf("cfg%0d reset ovf", i), ovf_v[i], 0);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("cfg%0d in_ready after reset", i), in_ready_v[i], 1);
    end

    directed("add ff+01", 16'h00FF, 16'h0001, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    directed("add 7f+01", 16'h007F, 16'h0001, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    directed("sub 05-07", 16'h0005, 16'h0007, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
    directed("sub 80-01", 16'h0080, 16'h0001, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);

    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drive_rand(1'b1);
      else in_valid = 1'b0;
      tick();
      if (i >= 1 && i <= 16) check("stream out_valid", out_valid_v[0], 1);
    end
    repeat (10) tick();

    for (int i = 0; i < 6; i++) begin
      drive_rand(1'b1);
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_rand(1'b1);
      tick();
      check("backpressure in_ready", in_ready_v[0], 0);
      check("backpressure out_valid", out_valid_v[0], 1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_rand(1'($urandom));
      tick();
    end
    in_valid = 1'b0;
    repeat (12) tick();

    for (int i = 0; i < 12; i++) begin
      drive_rand(1'b1);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("cfg%0d mid-reset out_valid", i), out_valid_v[i], 0);
      check($sformatf("cfg%0d mid-reset sum", i), sum_v[i], 0);
      check($sformatf("cfg%0d mid-reset cout", i), cout_v[i], 0);
      check($sformatf("cfg%0d mid-reset ovf", i), ovf_v[i], 0);
    end
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post-reset no stale out_valid", out_valid_v[0], 0);
    end
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("cfg%0d in_ready after mid reset", i), in_ready_v[i], 1);
    end

    for (int i = 0; i < 800; i++) begin
      drive_rand($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      tick();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("cfg%0d scoreboard drained", i), drained_v[i], 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
